flash_ram_loader: RTL and testbench



---
 rtl/flash_ram_loader_pkg.sv | 18 +
 rtl/flash_ram_loader_spi_shifter.sv | 57 +++++
 rtl/flash_ram_loader.sv | 167 ++++++++++++++++
 tb/tb_flash_ram_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/flash_ram_loader_pkg.sv
// Shared types and constants for the SPI-flash to RAM boot loader.
package flash_ram_loader_pkg;

  typedef enum logic [2:0] {
    Idle,
    StartupWait,
    SendCmd,
    SendAddr,
    ReadData,
    StartWrite,
    WaitWrite,
    Done
  } state_e;

  localparam logic [7:0] FlashCmdRead   = 8'h03;
  localparam logic [1:0] RamioWriteWord = 2'b11;

endpackage

// File: rtl/flash_ram_loader_spi_shifter.sv
// SPI mode-0 bit engine at clk/2: one 32-bit register shifts out MSB-first on
// send and shifts flash_miso in on receive; pulses field_done_o on the last bit.
module flash_spi_shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_i,
  input  logic        send_i,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  input  logic [4:0]  last_bit_i,
  input  logic        flash_miso_i,
  output logic        flash_clk_o,
  output logic        flash_mosi_o,
  output logic        field_done_o,
  output logic [7:0]  rx_byte_o
);

  logic        phase_q;
  logic        clk_q;
  logic        mosi_q;
  logic [4:0]  bit_cnt_q;
  logic [31:0] sr_q;

  assign field_done_o = run_i & phase_q & (bit_cnt_q == last_bit_i);
  // Includes the bit being sampled this cycle so the byte is usable at field_done_o.
  assign rx_byte_o    = {sr_q[6:0], flash_miso_i};
  assign flash_clk_o  = clk_q;
  assign flash_mosi_o = mosi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= 1'b0;
      clk_q     <= 1'b0;
      mosi_q    <= 1'b0;
      bit_cnt_q <= 5'd0;
      sr_q      <= 32'd0;
    end else if (load_i) begin
      phase_q   <= 1'b0;
      clk_q     <= 1'b0;
      bit_cnt_q <= 5'd0;
      sr_q      <= load_val_i;
    end else if (!run_i) begin
      phase_q <= 1'b0;
      clk_q   <= 1'b0;
    end else if (!phase_q) begin
      phase_q <= 1'b1;
      clk_q   <= 1'b0;
      if (send_i) mosi_q <= sr_q[31];
    end else begin
      phase_q   <= 1'b0;
      clk_q     <= 1'b1;
      sr_q      <= send_i ? {sr_q[30:0], 1'b0} : {sr_q[30:0], flash_miso_i};
      bit_cnt_q <= field_done_o ? 5'd0 : bit_cnt_q + 5'd1;
    end
  end

endmodule

// File: rtl/flash_ram_loader.sv
// Boot sequencer: streams a fixed-size image out of SPI flash (read 0x03) and
// writes it to RAM as little-endian 32-bit words through the ramio request port.
module flash_ram_loader
  import flash_ram_loader_pkg::*;
#(
  parameter int          TransferByteCount = 256,
  parameter int          StartupWaitCycles = 10,
  parameter logic [23:0] FlashStartAddress = 24'h00_0000,
  parameter logic [31:0] RamStartAddress   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        flash_clk,
  output logic        flash_mosi,
  input  logic        flash_miso,
  output logic        flash_cs_n,
  output logic        enable,
  output logic [1:0]  write_type,
  output logic [2:0]  read_type,
  output logic [31:0] address,
  output logic [31:0] data_in,
  input  logic        busy,
  output logic        done
);

  localparam int WordIdxW = $clog2(TransferByteCount / 4) + 1;
  localparam int WaitW    = $clog2(StartupWaitCycles + 1) + 1;

  if (TransferByteCount <= 0 || (TransferByteCount % 4) != 0) begin : g_bad_count
    $error("TransferByteCount must be a non-zero multiple of 4");
  end

  state_e                state_q, state_d;
  logic [WaitW-1:0]      wait_cnt_q, wait_cnt_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [31:0]           word_q, word_d;
  logic [WordIdxW-1:0]   word_idx_q, word_idx_d;
  logic                  first_q, first_d;
  logic                  enable_q, enable_d;
  logic [1:0]            write_type_q, write_type_d;
  logic [31:0]           address_q, address_d;
  logic [31:0]           data_in_q, data_in_d;

  logic       spi_run, spi_send, spi_load, field_done;
  logic [4:0] spi_last;
  logic [7:0] rx_byte;

  flash_spi_shifter u_shifter (
    .clk          (clk),
    .rst_n        (rst_n),
    .run_i        (spi_run),
    .send_i       (spi_send),
    .load_i       (spi_load),
    .load_val_i   ({FlashCmdRead, FlashStartAddress}),
    .last_bit_i   (spi_last),
    .flash_miso_i (flash_miso),
    .flash_clk_o  (flash_clk),
    .flash_mosi_o (flash_mosi),
    .field_done_o (field_done),
    .rx_byte_o    (rx_byte)
  );

  // Chip select stays low across every word so the flash sees one continuous read.
  assign flash_cs_n = !(state_q inside {SendCmd, SendAddr, ReadData, StartWrite, WaitWrite});
  assign done       = (state_q == Done);
  assign enable     = enable_q;
  assign write_type = write_type_q;
  assign read_type  = 3'd0;
  assign address    = address_q;
  assign data_in    = data_in_q;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    word_idx_d   = word_idx_q;
    first_d      = first_q;
    enable_d     = 1'b0;
    write_type_d = 2'b00;
    address_d    = address_q;
    data_in_d    = data_in_q;
    spi_run      = 1'b0;
    spi_send     = 1'b0;
    spi_load     = 1'b0;
    spi_last     = 5'd7;
    case (state_q)
      Idle: begin
        if (start) begin
          state_d    = StartupWait;
          wait_cnt_d = '0;
        end
      end
      StartupWait: begin
        spi_load = 1'b1;
        if (int'(wait_cnt_q) + 1 >= StartupWaitCycles) state_d = SendCmd;
        else wait_cnt_d = wait_cnt_q + 1'b1;
      end
      SendCmd: begin
        spi_run  = 1'b1;
        spi_send = 1'b1;
        if (field_done) state_d = SendAddr;
      end
      SendAddr: begin
        spi_run    = 1'b1;
        spi_send   = 1'b1;
        spi_last   = 5'd23;
        byte_idx_d = 2'd0;
        if (field_done) state_d = ReadData;
      end
      ReadData: begin
        spi_run = 1'b1;
        if (field_done) begin
          word_d[{byte_idx_q, 3'b000} +: 8] = rx_byte;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) state_d = StartWrite;
        end
      end
      StartWrite: begin
        if (!busy) begin
          enable_d     = 1'b1;
          write_type_d = RamioWriteWord;
          address_d    = RamStartAddress + (32'(word_idx_q) << 2);
          data_in_d    = word_q;
          word_idx_d   = word_idx_q + 1'b1;
          first_d      = 1'b1;
          state_d      = WaitWrite;
        end
      end
      WaitWrite: begin
        // ramio raises busy a cycle after enable, so the first cycle proves nothing.
        if (first_q) first_d = 1'b0;
        else if (!busy) state_d = (int'(word_idx_q) < TransferByteCount / 4) ? ReadData : Done;
      end
      Done: ;
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= Idle;
      wait_cnt_q   <= '0;
      byte_idx_q   <= 2'd0;
      word_q       <= 32'd0;
      word_idx_q   <= '0;
      first_q      <= 1'b0;
      enable_q     <= 1'b0;
      write_type_q <= 2'b00;
      address_q    <= 32'd0;
      data_in_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      word_idx_q   <= word_idx_d;
      first_q      <= first_d;
      enable_q     <= enable_d;
      write_type_q <= write_type_d;
      address_q    <= address_d;
      data_in_q    <= data_in_d;
    end
  end

endmodule

// File: tb/tb_flash_ram_loader.sv
// Directed bench for flash_ram_loader with a behavioural SPI flash and ramio model.
module tb_flash_ram_loader;

  logic        clk, rst_n, start;
  logic        flash_clk, flash_mosi, miso, flash_cs_n;
  logic        enable, busy, done;
  logic [1:0]  write_type;
  logic [2:0]  read_type;
  logic [31:0] address, data_in;

  int total = 0;
  int bad   = 0;

  flash_ram_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .flash_clk  (flash_clk),
    .flash_mosi (flash_mosi),
    .flash_miso (miso),
    .flash_cs_n (flash_cs_n),
    .enable     (enable),
    .write_type (write_type),
    .read_type  (read_type),
    .address    (address),
    .data_in    (data_in),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Flash image: byte-wise formula, bytes 16..19 fixed so word 4 is D5B8A9C4.
  function automatic logic [7:0] fbyte(input int i);
    case (i)
      16:      return 8'hC4;
      17:      return 8'hA9;
      18:      return 8'hB8;
      19:      return 8'hD5;
      default: return 8'((i * 37 + 11) & 255);
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input int w);
    return {fbyte(4*w+3), fbyte(4*w+2), fbyte(4*w+1), fbyte(4*w)};
  endfunction

  // SPI flash model, evaluated on the falling system-clock edge.
  int          cyc = 0, last_rise = 0, rx_cnt = 0, out_bit = 0, gap_bad = 0;
  logic        prev_fclk = 1'b0;
  logic [31:0] cmd_addr = 32'd0;
  logic [7:0]  fb;
  initial miso = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (flash_cs_n) begin
      rx_cnt  = 0;
      out_bit = 0;
    end else begin
      if (flash_clk && !prev_fclk && rx_cnt < 32) begin
        cmd_addr = {cmd_addr[30:0], flash_mosi};
        if (rx_cnt > 0 && cyc - last_rise != 2) gap_bad++;
        last_rise = cyc;
        rx_cnt++;
      end
      if (!flash_clk && prev_fclk && rx_cnt == 32) begin
        fb   = fbyte((out_bit / 8) % 256);
        miso = fb[7 - (out_bit % 8)];
        out_bit++;
      end
    end
    prev_fclk = flash_clk;
  end

  // ramio model: busy rises the cycle after enable and holds for two cycles.
  logic [31:0] ram [64];
  int   wr_cnt = 0, addr_bad = 0, dbl_en = 0, stall_viol = 0, bcnt = 0;
  logic pend = 1'b0, mbusy = 1'b0, need_idle = 1'b0, force_busy = 1'b0;
  assign busy = mbusy | force_busy;
  always @(negedge clk) begin
    if (!rst_n) begin
      wr_cnt = 0; pend = 1'b0; mbusy = 1'b0; bcnt = 0; need_idle = 1'b0;
      for (int i = 0; i < 64; i++) ram[i] = 32'd0;
    end else begin
      if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) mbusy = 1'b0;
      end
      if (pend) begin
        pend = 1'b0; mbusy = 1'b1; bcnt = 2;
      end
      if (enable) begin
        if (need_idle) dbl_en++;
        need_idle = 1'b1;
        if (address != 32'(wr_cnt * 4) || write_type != 2'b11 || read_type != 3'd0) addr_bad++;
        ram[address[7:2]] = data_in;
        wr_cnt++;
        pend = 1'b1;
      end else if (!busy) need_idle = 1'b0;
      if (force_busy && (enable || flash_clk)) stall_viol++;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_writes(input int n);
    for (int i = 0; i < 20000 && wr_cnt < n; i++) @(posedge clk);
    chk("wr_reach", 32'(wr_cnt >= n), 32'd1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 30000 && !done; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk("done_set", 32'(done), 32'd1);
  endtask

  task automatic check_image(input string tag);
    int wbad;
    wbad = 0;
    for (int w = 0; w < 64; w++) if (ram[w] !== exp_word(w)) wbad++;
    chk({tag, "_wr_cnt"}, 32'(wr_cnt), 32'd64);
    chk({tag, "_words"}, 32'(wbad), 32'd0);
    chk({tag, "_word16"}, ram[4], 32'hD5B8A9C4);
    chk({tag, "_addr_type"}, 32'(addr_bad), 32'd0);
    chk({tag, "_dbl_en"}, 32'(dbl_en), 32'd0);
    chk({tag, "_cs_n"}, 32'(flash_cs_n), 32'd1);
  endtask

  initial begin
    int quiet_bad, n;
    do_reset();
    #1;
    chk("rst_address", address, 32'd0);
    chk("rst_data_in", data_in, 32'd0);
    chk("rst_wtype", 32'(write_type), 32'd0);
    chk("rst_rtype", 32'(read_type), 32'd0);
    chk("rst_mosi", 32'(flash_mosi), 32'd0);
    quiet_bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (flash_cs_n !== 1'b1 || flash_clk !== 1'b0 || enable !== 1'b0 || done !== 1'b0) quiet_bad++;
    end
    chk("idle_quiet", 32'(quiet_bad), 32'd0);

    // Run 1: framing then full boot.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    n = 0;
    while (n < 50 && flash_cs_n) begin
      @(posedge clk); #1; n++;
    end
    chk("cs_delay", 32'(n), 32'd10);
    for (int i = 0; i < 200 && rx_cnt < 32; i++) @(posedge clk);
    chk("cmd_addr", cmd_addr, 32'h0300_0000);
    chk("clk_period", 32'(gap_bad), 32'd0);
    wait_done();
    check_image("boot");

    // Run 2: busy stall after the third write.
    do_reset();
    start = 1'b1;
    wait_writes(3);
    force_busy = 1'b1;
    n = wr_cnt;
    repeat (50) @(posedge clk);
    chk("stall_no_wr", 32'(wr_cnt - n), 32'd0);
    force_busy = 1'b0;
    chk("stall_viol", 32'(stall_viol), 32'd0);
    wait_done();
    check_image("stall");

    // Run 3: asynchronous reset in the middle of the load, then restart.
    do_reset();
    start = 1'b1;
    wait_writes(10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_cs_n", 32'(flash_cs_n), 32'd1);
    chk("abort_en", 32'(enable), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_done();
    check_image("rerun");

    // start toggling after done has no effect.
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk); start = 1'b1;
    repeat (5) @(negedge clk); start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("sticky_done", 32'(done), 32'd1);
    chk("sticky_wr", 32'(wr_cnt), 32'd64);
    chk("sticky_cs_n", 32'(flash_cs_n), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
